armleocpu_cache_arbiter: RTL and testbench

Shares one cache port (armleocpu_cache command/response protocol) between the fetch unit and the execute/memory unit. It sits between armleocpu_fetch / execute and the single unified cache. It forwards the granted requester's command and address to the cache in the same cycle. It returns responses only to the current owner, and makes any losing requester hold its command via a WAIT response.

---
 rtl/armleocpu_cache_arbiter_pkg.sv | 30 +++
 rtl/armleocpu_arb_pick2.sv | 26 ++
 rtl/armleocpu_cache_arbiter.sv | 111 +++++++++++
 tb/tb_armleocpu_cache_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/armleocpu_cache_arbiter_pkg.sv
// Shared cache command/response encodings, arbiter owner encoding and the terminal-response helper.
// The arbitration policy is selected by ARMLEOCPU_CACHE_ARB_RR_EN (see armleocpu_arb_pick2).
package armleocpu_cache_arbiter_pkg;

  localparam logic [3:0] CACHE_CMD_NONE      = 4'd0;
  localparam logic [3:0] CACHE_CMD_EXECUTE   = 4'd1;
  localparam logic [3:0] CACHE_CMD_LOAD      = 4'd2;
  localparam logic [3:0] CACHE_CMD_STORE     = 4'd3;
  localparam logic [3:0] CACHE_CMD_FLUSH_ALL = 4'd4;

  localparam logic [3:0] CACHE_RESPONSE_IDLE        = 4'd0;
  localparam logic [3:0] CACHE_RESPONSE_WAIT        = 4'd1;
  localparam logic [3:0] CACHE_RESPONSE_DONE        = 4'd2;
  localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT = 4'd3;
  localparam logic [3:0] CACHE_RESPONSE_PAGEFAULT   = 4'd4;
  localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED = 4'd5;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_F    = 2'd1;
  localparam logic [1:0] OWN_E    = 2'd2;

  localparam logic GRANT_F = 1'b0;
  localparam logic GRANT_E = 1'b1;

  function automatic logic is_terminal(input logic [3:0] resp);
    return (resp == CACHE_RESPONSE_DONE) || (resp == CACHE_RESPONSE_ACCESSFAULT) ||
           (resp == CACHE_RESPONSE_MISSALIGNED) || (resp == CACHE_RESPONSE_PAGEFAULT);
  endfunction

endpackage

// File: rtl/armleocpu_arb_pick2.sv
// Combinational two-requester picker. ARMLEOCPU_CACHE_ARB_RR_EN selects round-robin;
// otherwise execute has fixed priority over fetch.
module armleocpu_arb_pick2
  import armleocpu_cache_arbiter_pkg::*;
(
  input  logic i_valid_f,
  input  logic i_valid_e,
  input  logic i_last_grant,
  output logic o_grant_f,
  output logic o_grant_e
);

`ifdef ARMLEOCPU_CACHE_ARB_RR_EN
  logic w_contend;
  assign w_contend = i_valid_f & i_valid_e;
  // On contention the requester that was not served last wins.
  assign o_grant_e = w_contend ? (i_last_grant == GRANT_F) : i_valid_e;
  assign o_grant_f = w_contend ? (i_last_grant == GRANT_E) : i_valid_f;
`else
  logic w_unused;
  assign w_unused  = i_last_grant;
  assign o_grant_e = i_valid_e;
  assign o_grant_f = i_valid_f & ~i_valid_e;
`endif

endmodule

// File: rtl/armleocpu_cache_arbiter.sv
// Shares one cache port between fetch and execute with zero-cycle command forwarding.
// Policy: ARMLEOCPU_CACHE_ARB_RR_EN defined -> round-robin, undefined -> execute priority.
module armleocpu_cache_arbiter
  import armleocpu_cache_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_reset_done,
  output logic [3:0]  c_cmd,
  output logic [31:0] c_address,
  output logic [31:0] c_store_data,
  input  logic [3:0]  c_response,
  input  logic [31:0] c_load_data,
  input  logic [3:0]  f_cmd,
  input  logic [31:0] f_address,
  output logic [3:0]  f_response,
  output logic [31:0] f_load_data,
  input  logic [3:0]  e_cmd,
  input  logic [31:0] e_address,
  input  logic [31:0] e_store_data,
  output logic [3:0]  e_response,
  output logic [31:0] e_load_data
);

  logic [1:0] r_owner;
  logic       r_last_grant;
  logic       r_f_denied;
  logic       r_e_denied;

  logic w_enabled;
  logic w_owned;
  logic w_free;
  logic w_f_valid;
  logic w_e_valid;
  logic w_grant_f;
  logic w_grant_e;
  logic w_sel_f;
  logic w_sel_e;

  assign w_enabled = rst_n & c_reset_done;
  assign w_owned   = (r_owner != OWN_NONE);
  // Terminal responses free the port; IDLE while owned is a cache protocol error and also frees it.
  assign w_free    = !w_owned || is_terminal(c_response) || (c_response == CACHE_RESPONSE_IDLE);
  assign w_f_valid = (f_cmd != CACHE_CMD_NONE);
  assign w_e_valid = (e_cmd != CACHE_CMD_NONE);

  armleocpu_arb_pick2 u_pick2 (
    .i_valid_f    (w_f_valid),
    .i_valid_e    (w_e_valid),
    .i_last_grant (r_last_grant),
    .o_grant_f    (w_grant_f),
    .o_grant_e    (w_grant_e)
  );

  always_comb begin
    w_sel_f = 1'b0;
    w_sel_e = 1'b0;
    if (w_enabled) begin
      if (w_free) begin
        w_sel_f = w_grant_f;
        w_sel_e = w_grant_e;
      end else begin
        w_sel_f = (r_owner == OWN_F);
        w_sel_e = (r_owner == OWN_E);
      end
    end
  end

  always_comb begin
    c_cmd        = CACHE_CMD_NONE;
    c_address    = 32'd0;
    c_store_data = 32'd0;
    if (w_sel_e) begin
      c_cmd        = e_cmd;
      c_address    = e_address;
      c_store_data = e_store_data;
    end else if (w_sel_f) begin
      c_cmd     = f_cmd;
      c_address = f_address;
    end
  end

  always_comb begin
    f_response = CACHE_RESPONSE_IDLE;
    e_response = CACHE_RESPONSE_IDLE;
    if (w_enabled) begin
      if (r_owner == OWN_F) f_response = c_response;
      else if (r_f_denied)  f_response = CACHE_RESPONSE_WAIT;
      if (r_owner == OWN_E) e_response = c_response;
      else if (r_e_denied)  e_response = CACHE_RESPONSE_WAIT;
    end
  end

  assign f_load_data = c_load_data;
  assign e_load_data = c_load_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner      <= OWN_NONE;
      r_last_grant <= GRANT_F;
      r_f_denied   <= 1'b0;
      r_e_denied   <= 1'b0;
    end else if (c_reset_done) begin
      r_owner      <= w_sel_e ? OWN_E : (w_sel_f ? OWN_F : OWN_NONE);
      r_last_grant <= w_sel_e ? GRANT_E : (w_sel_f ? GRANT_F : r_last_grant);
      r_f_denied   <= w_f_valid & ~w_sel_f;
      r_e_denied   <= w_e_valid & ~w_sel_e;
    end
  end

endmodule

// File: tb/tb_armleocpu_cache_arbiter.sv
// Table-driven self-checking bench for armleocpu_cache_arbiter with an expectation queue.
// Expectations follow ARMLEOCPU_CACHE_ARB_RR_EN when the bench is built with it.
module tb_armleocpu_cache_arbiter;
  import armleocpu_cache_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        c_reset_done;
  logic [3:0]  c_cmd;
  logic [31:0] c_address;
  logic [31:0] c_store_data;
  logic [3:0]  c_response;
  logic [31:0] c_load_data;
  logic [3:0]  f_cmd;
  logic [31:0] f_address;
  logic [3:0]  f_response;
  logic [31:0] f_load_data;
  logic [3:0]  e_cmd;
  logic [31:0] e_address;
  logic [31:0] e_store_data;
  logic [3:0]  e_response;
  logic [31:0] e_load_data;

  armleocpu_cache_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .c_reset_done (c_reset_done),
    .c_cmd        (c_cmd),
    .c_address    (c_address),
    .c_store_data (c_store_data),
    .c_response   (c_response),
    .c_load_data  (c_load_data),
    .f_cmd        (f_cmd),
    .f_address    (f_address),
    .f_response   (f_response),
    .f_load_data  (f_load_data),
    .e_cmd        (e_cmd),
    .e_address    (e_address),
    .e_store_data (e_store_data),
    .e_response   (e_response),
    .e_load_data  (e_load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        rd;
    logic [3:0]  fc;
    logic [31:0] fa;
    logic [3:0]  ec;
    logic [31:0] ea;
    logic [31:0] esd;
    logic [3:0]  cr;
    logic [3:0]  x_cmd;
    logic [31:0] x_addr;
    logic [31:0] x_sd;
    logic [3:0]  x_f;
    logic [3:0]  x_e;
  } vec_t;

  typedef struct {
    logic [3:0]  x_cmd;
    logic [31:0] x_addr;
    logic [31:0] x_sd;
    logic [3:0]  x_f;
    logic [3:0]  x_e;
    logic [31:0] x_ld;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec;
  int   n_err;

  localparam logic [3:0] N  = CACHE_CMD_NONE;
  localparam logic [3:0] EX = CACHE_CMD_EXECUTE;
  localparam logic [3:0] LD = CACHE_CMD_LOAD;
  localparam logic [3:0] ST = CACHE_CMD_STORE;
  localparam logic [3:0] FL = CACHE_CMD_FLUSH_ALL;
  localparam logic [3:0] RI = CACHE_RESPONSE_IDLE;
  localparam logic [3:0] RW = CACHE_RESPONSE_WAIT;
  localparam logic [3:0] RD = CACHE_RESPONSE_DONE;
  localparam logic [3:0] RP = CACHE_RESPONSE_PAGEFAULT;

  function automatic void add(input logic r, input logic rd, input logic [3:0] fc,
                              input logic [31:0] fa, input logic [3:0] ec, input logic [31:0] ea,
                              input logic [31:0] esd, input logic [3:0] cr, input logic [3:0] xc,
                              input logic [31:0] xa, input logic [31:0] xs, input logic [3:0] xf,
                              input logic [3:0] xe);
    vec_t v;
    v.rst_n = r;  v.rd = rd; v.fc = fc; v.fa = fa; v.ec = ec; v.ea = ea; v.esd = esd;
    v.cr = cr; v.x_cmd = xc; v.x_addr = xa; v.x_sd = xs; v.x_f = xf; v.x_e = xe;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t x;
    exp_t got;
    @(negedge clk);
    rst_n        = v.rst_n;
    c_reset_done = v.rd;
    f_cmd        = v.fc;
    f_address    = v.fa;
    e_cmd        = v.ec;
    e_address    = v.ea;
    e_store_data = v.esd;
    c_response   = v.cr;
    c_load_data  = 32'hC0DE_0000 + 32'(n_vec);
    x.x_cmd = v.x_cmd; x.x_addr = v.x_addr; x.x_sd = v.x_sd;
    x.x_f = v.x_f; x.x_e = v.x_e; x.x_ld = 32'hC0DE_0000 + 32'(n_vec);
    sb.push_back(x);
    #2;
    got = sb.pop_front();
    chk($sformatf("v%0d c_cmd", n_vec), 32'(c_cmd), 32'(got.x_cmd));
    chk($sformatf("v%0d c_address", n_vec), c_address, got.x_addr);
    chk($sformatf("v%0d c_store_data", n_vec), c_store_data, got.x_sd);
    chk($sformatf("v%0d f_response", n_vec), 32'(f_response), 32'(got.x_f));
    chk($sformatf("v%0d e_response", n_vec), 32'(e_response), 32'(got.x_e));
    chk($sformatf("v%0d f_load_data", n_vec), f_load_data, got.x_ld);
    chk($sformatf("v%0d e_load_data", n_vec), e_load_data, got.x_ld);
    n_vec++;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; c_reset_done = 1'b0; f_cmd = N; f_address = 0; e_cmd = N;
    e_address = 0; e_store_data = 0; c_response = RI; c_load_data = 0;

    // Reset and cache-reset-pending: everything quiet.
    add(0, 0, EX, 32'h2000, LD, 32'h100, 32'h55, RI, N, 0, 0, RI, RI);
    add(1, 0, EX, 32'h2000, N, 0, 0, RI, N, 0, 0, RI, RI);
    // Fetch only: forward, two WAITs, DONE with back-to-back next fetch.
    add(1, 1, EX, 32'h2000, N, 0, 0, RI, EX, 32'h2000, 0, RI, RI);
    add(1, 1, EX, 32'h2000, N, 0, 0, RW, EX, 32'h2000, 0, RW, RI);
    add(1, 1, EX, 32'h2000, N, 0, 0, RW, EX, 32'h2000, 0, RW, RI);
    add(1, 1, EX, 32'h2004, N, 0, 0, RD, EX, 32'h2004, 0, RD, RI);
    add(1, 1, N, 0, N, 0, 0, RD, N, 0, 0, RD, RI);
    // Both valid in an idle cycle: execute wins, fetch waits, fetch wins at DONE.
    add(1, 1, EX, 32'h3000, LD, 32'h100, 32'hAA, RI, LD, 32'h100, 32'hAA, RI, RI);
    add(1, 1, EX, 32'h3000, LD, 32'h100, 32'hAA, RW, LD, 32'h100, 32'hAA, RW, RW);
    add(1, 1, EX, 32'h3000, N, 0, 0, RD, EX, 32'h3000, 0, RW, RD);
    add(1, 1, EX, 32'h3000, N, 0, 0, RW, EX, 32'h3000, 0, RW, RI);
    // Execute PAGEFAULT hands the port to the waiting fetch in the same cycle.
    add(1, 1, N, 0, LD, 32'h200, 32'h11, RD, LD, 32'h200, 32'h11, RD, RI);
    add(1, 1, EX, 32'h4000, LD, 32'h200, 32'h11, RW, LD, 32'h200, 32'h11, RI, RW);
    add(1, 1, EX, 32'h4000, LD, 32'h200, 32'h11, RW, LD, 32'h200, 32'h11, RW, RW);
    add(1, 1, EX, 32'h4000, N, 0, 0, RP, EX, 32'h4000, 0, RW, RP);
    add(1, 1, EX, 32'h4000, N, 0, 0, RW, EX, 32'h4000, 0, RW, RI);
    // Cache answers IDLE while owned: owner released, waiting execute granted.
    add(1, 1, EX, 32'h4000, ST, 32'h300, 32'h22, RW, EX, 32'h4000, 0, RW, RI);
    add(1, 1, EX, 32'h4000, ST, 32'h300, 32'h22, RI, ST, 32'h300, 32'h22, RI, RW);
    add(1, 1, EX, 32'h4000, ST, 32'h300, 32'h22, RW, ST, 32'h300, 32'h22, RW, RW);
    // Reset during owned WAIT, then cache reset pending blocks grants.
    add(0, 1, EX, 32'h4000, ST, 32'h300, 32'h22, RW, N, 0, 0, RI, RI);
    add(1, 0, EX, 32'h4000, ST, 32'h300, 32'h22, RI, N, 0, 0, RI, RI);
    add(1, 0, EX, 32'h4000, ST, 32'h300, 32'h22, RI, N, 0, 0, RI, RI);
    add(1, 1, EX, 32'h4000, ST, 32'h300, 32'h22, RI, ST, 32'h300, 32'h22, RI, RI);
    add(1, 1, EX, 32'h4000, N, 0, 0, RD, EX, 32'h4000, 0, RW, RD);
    add(1, 1, N, 0, N, 0, 0, RD, N, 0, 0, RD, RI);
    // Continuous contention for six single-cycle accesses.
    add(1, 1, EX, 32'h5000, LD, 32'h600, 0, RI, LD, 32'h600, 0, RI, RI);
`ifdef ARMLEOCPU_CACHE_ARB_RR_EN
    add(1, 1, EX, 32'h5000, LD, 32'h600, 0, RD, EX, 32'h5000, 0, RW, RD);
    add(1, 1, EX, 32'h5000, LD, 32'h600, 0, RD, LD, 32'h600, 0, RD, RW);
    add(1, 1, EX, 32'h5000, LD, 32'h600, 0, RD, EX, 32'h5000, 0, RW, RD);
    add(1, 1, EX, 32'h5000, LD, 32'h600, 0, RD, LD, 32'h600, 0, RD, RW);
    add(1, 1, EX, 32'h5000, LD, 32'h600, 0, RD, EX, 32'h5000, 0, RW, RD);
    add(1, 1, N, 0, N, 0, 0, RD, N, 0, 0, RD, RW);
`else
    for (int i = 0; i < 5; i++) add(1, 1, EX, 32'h5000, LD, 32'h600, 0, RD, LD, 32'h600, 0, RW, RD);
    add(1, 1, N, 0, N, 0, 0, RD, N, 0, 0, RW, RD);
`endif
    add(1, 1, N, 0, N, 0, 0, RI, N, 0, 0, RI, RI);
    // FLUSH_ALL owns the port; fetch sees WAIT.
    add(1, 1, EX, 32'h6000, FL, 0, 0, RI, FL, 0, 0, RI, RI);
    add(1, 1, EX, 32'h6000, FL, 0, 0, RW, FL, 0, 0, RW, RW);
    add(1, 1, EX, 32'h6000, N, 0, 0, RD, EX, 32'h6000, 0, RW, RD);
    add(1, 1, N, 0, N, 0, 0, RD, N, 0, 0, RD, RI);

    foreach (vecs[i]) apply(vecs[i]);

    // Hand-written sequence: long fetch miss with execute queued behind it.
    begin
      vec_t v;
      v = '{1, 1, EX, 32'h7000, N, 0, 0, RI, EX, 32'h7000, 0, RI, RI};
      apply(v);
      v = '{1, 1, EX, 32'h7000, ST, 32'h700, 32'h77, RW, EX, 32'h7000, 0, RW, RI};
      apply(v);
      v.x_e = RW;
      for (int i = 0; i < 4; i++) apply(v);
      v = '{1, 1, N, 0, ST, 32'h700, 32'h77, RD, ST, 32'h700, 32'h77, RD, RW};
      apply(v);
      v = '{1, 1, N, 0, N, 0, 0, RD, N, 0, 0, RI, RD};
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
